// File: rtl/sys_defs.sv
// Shared definitions for the branch reservation station and the branch execute unit.
// Provides the data-path widths, the default reservation-station depth, the
// issue/dispatch packet layout and a CDB wakeup helper.
package sys_defs;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned PRF_LEN        = 6;
  localparam int unsigned ROB_LEN        = 5;
  localparam int unsigned RS_BRANCH_SIZE = 4;

  // Branch packet exchanged between dispatch, the RS and the branch execute unit.
  typedef struct packed {
    logic [XLEN-1:0]    PC;
    logic [XLEN-1:0]    offset;
    logic               cond_branch;
    logic [PRF_LEN-1:0] opa_preg_idx;
    logic               opa_ready;
    logic [XLEN-1:0]    opa_value;
    logic [PRF_LEN-1:0] opb_preg_idx;
    logic               opb_ready;
    logic [XLEN-1:0]    opb_value;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic               br_pred_direction;
    logic [XLEN-1:0]    br_pred_target_PC;
    logic               local_pred_direction;
    logic               global_pred_direction;
  } RS_BRANCH_PACKET;

  // Capture a CDB broadcast into any not-yet-ready operand whose tag matches.
  function automatic RS_BRANCH_PACKET rs_wake(
    input RS_BRANCH_PACKET    p,
    input logic               cdb_v,
    input logic [PRF_LEN-1:0] cdb_tag,
    input logic [XLEN-1:0]    cdb_val
  );
    RS_BRANCH_PACKET r;
    r = p;
    if (cdb_v && !p.opa_ready && (p.opa_preg_idx == cdb_tag)) begin
      r.opa_ready = 1'b1;
      r.opa_value = cdb_val;
    end
    if (cdb_v && !p.opb_ready && (p.opb_preg_idx == cdb_tag)) begin
      r.opb_ready = 1'b1;
      r.opb_value = cdb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps_age_select.sv
// Oldest-ready selector driven by an age matrix.
// age_i[i][j] = 1 means entry i is older than entry j.
// Ports:
//   ready_i    - per-entry ready vector
//   age_i      - N x N age matrix
//   grant_c_o  - one-hot grant of the oldest ready entry (combinational)
//   valid_c_o  - some entry is granted (combinational)
module ps_age_select #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        ready_i,
  input  logic [N-1:0][N-1:0] age_i,
  output logic [N-1:0]        grant_c_o,
  output logic                valid_c_o
);

  logic [N-1:0] blocked;

  // An entry is blocked when any older entry is also ready.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        blocked[i] = blocked[i] | (ready_i[j] & age_i[j][i]);
      end
    end
  end

  assign grant_c_o = ready_i & ~blocked;
  assign valid_c_o = |grant_c_o;

endmodule

// File: rtl/rs_branch.sv
// Reservation station for the branch functional unit.
// Buffers dispatched branches, captures operands from the CDB and issues the
// oldest entry with both operands ready as a registered packet.
// Ports:
//   clock, reset        - clock and asynchronous active-low reset
//   squash              - mispredict flush, clears every entry
//   dispatch_valid/packet - incoming branch from dispatch
//   cdb_valid/preg_idx/value - common data bus broadcast
//   fu_busy             - branch unit cannot accept an issue this cycle
//   rs_branch_full      - all entries occupied (from registered state)
//   branch_enable       - registered issue valid
//   rs_branch_packet    - registered issued packet
module rs_branch
  import sys_defs::*;
#(
  parameter int unsigned RS_BRANCH_SIZE      = sys_defs::RS_BRANCH_SIZE,
  parameter int unsigned RS_BRANCH_LEN       = $clog2(RS_BRANCH_SIZE),
  parameter bit          CHECK_DISPATCH_FULL = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               squash,
  input  logic               dispatch_valid,
  input  RS_BRANCH_PACKET    dispatch_packet,
  input  logic               cdb_valid,
  input  logic [PRF_LEN-1:0] cdb_preg_idx,
  input  logic [XLEN-1:0]    cdb_value,
  input  logic               fu_busy,
  output logic               rs_branch_full,
  output logic               branch_enable,
  output RS_BRANCH_PACKET    rs_branch_packet
);

  localparam int unsigned N = RS_BRANCH_SIZE;

  logic [N-1:0]              valid_q, valid_d;
  RS_BRANCH_PACKET [N-1:0]   entry_q, entry_d;
  logic [N-1:0][N-1:0]       age_q, age_d;
  logic                      branch_enable_q, branch_enable_d;
  RS_BRANCH_PACKET           out_pkt_q, out_pkt_d;

  logic [N-1:0]              ready_c;
  logic [N-1:0]              grant_c;
  logic                      grant_valid_c;
  logic [RS_BRANCH_LEN-1:0]  sel_idx_c;
  logic [RS_BRANCH_LEN-1:0]  free_idx_c;
  logic                      issue_c;
  logic                      alloc_c;

  // Readiness is judged on registered state only, so a wakeup costs one cycle.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      ready_c[i] = valid_q[i] & entry_q[i].opa_ready & entry_q[i].opb_ready;
    end
  end

  ps_age_select #(.N(N)) u_age_select (
    .ready_i   (ready_c),
    .age_i     (age_q),
    .grant_c_o (grant_c),
    .valid_c_o (grant_valid_c)
  );

  // One-hot grant to index, and lowest-index free slot.
  always_comb begin
    sel_idx_c  = '0;
    free_idx_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_c[i]) sel_idx_c = RS_BRANCH_LEN'(i);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx_c = RS_BRANCH_LEN'(i);
    end
  end

  assign rs_branch_full = &valid_q;
  assign issue_c        = grant_valid_c & ~fu_busy & ~squash;
  assign alloc_c        = dispatch_valid & ~rs_branch_full & ~squash;

  // Next-state: wakeup, allocation, issue, then squash overriding all.
  always_comb begin
    valid_d         = valid_q;
    entry_d         = entry_q;
    age_d           = age_q;
    branch_enable_d = 1'b0;
    out_pkt_d       = out_pkt_q;

    for (int i = 0; i < int'(N); i++) begin
      if (valid_q[i]) begin
        entry_d[i] = rs_wake(entry_q[i], cdb_valid, cdb_preg_idx, cdb_value);
      end
    end

    if (issue_c) begin
      branch_enable_d = 1'b1;
      out_pkt_d       = entry_q[sel_idx_c];
    end

    // New entry is younger than every entry valid before this edge.
    if (alloc_c) begin
      valid_d[free_idx_c] = 1'b1;
      entry_d[free_idx_c] = rs_wake(dispatch_packet, cdb_valid, cdb_preg_idx, cdb_value);
      for (int j = 0; j < int'(N); j++) begin
        age_d[j][free_idx_c] = valid_q[j];
        age_d[free_idx_c][j] = 1'b0;
      end
    end

    // Applied after allocation so the issued slot's row/column end up clear.
    if (issue_c) begin
      valid_d[sel_idx_c] = 1'b0;
      for (int j = 0; j < int'(N); j++) begin
        age_d[sel_idx_c][j] = 1'b0;
        age_d[j][sel_idx_c] = 1'b0;
      end
    end

    if (squash) begin
      valid_d         = '0;
      age_d           = '0;
      branch_enable_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q         <= '0;
      entry_q         <= '0;
      age_q           <= '0;
      branch_enable_q <= 1'b0;
      out_pkt_q       <= '0;
    end else begin
      valid_q         <= valid_d;
      entry_q         <= entry_d;
      age_q           <= age_d;
      branch_enable_q <= branch_enable_d;
      out_pkt_q       <= out_pkt_d;
    end
  end

  assign branch_enable    = branch_enable_q;
  assign rs_branch_packet = out_pkt_q;

  // Dispatch into a full station is dropped; flag it so upstream stalls get fixed.
  if (CHECK_DISPATCH_FULL) begin : g_full_check
    a_no_dispatch_when_full: assert property (
      @(posedge clock) disable iff (!reset)
      !(dispatch_valid && rs_branch_full && !squash)
    );
  end

endmodule

// File: tb/tb_rs_branch.sv
module tb_rs_branch;
  import sys_defs::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               squash;
  logic               dispatch_valid;
  RS_BRANCH_PACKET    dispatch_packet;
  logic               cdb_valid;
  logic [PRF_LEN-1:0] cdb_preg_idx;
  logic [XLEN-1:0]    cdb_value;
  logic               fu_busy;
  logic               rs_branch_full;
  logic               branch_enable;
  RS_BRANCH_PACKET    rs_branch_packet;

  int checks   = 0;
  int failures = 0;

  RS_BRANCH_PACKET p, pa, pb, exp_pkt;

  always #5 clock = ~clock;

  rs_branch #(
    .RS_BRANCH_SIZE      (4),
    .CHECK_DISPATCH_FULL (1'b0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .squash           (squash),
    .dispatch_valid   (dispatch_valid),
    .dispatch_packet  (dispatch_packet),
    .cdb_valid        (cdb_valid),
    .cdb_preg_idx     (cdb_preg_idx),
    .cdb_value        (cdb_value),
    .fu_busy          (fu_busy),
    .rs_branch_full   (rs_branch_full),
    .branch_enable    (branch_enable),
    .rs_branch_packet (rs_branch_packet)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // opb is always ready (tag 2); opa tag/ready/value chosen per test.
  function automatic RS_BRANCH_PACKET mk(input logic [31:0] pc, input logic [5:0] atag,
                                         input logic ardy, input logic [31:0] aval,
                                         input logic [31:0] bval);
    RS_BRANCH_PACKET r;
    r = '0;
    r.PC                    = pc;
    r.offset                = 32'h20;
    r.cond_branch           = 1'b1;
    r.opa_preg_idx          = atag;
    r.opa_ready             = ardy;
    r.opa_value             = aval;
    r.opb_preg_idx          = 6'd2;
    r.opb_ready             = 1'b1;
    r.opb_value             = bval;
    r.dest_preg_idx         = pc[9:4];
    r.rob_idx               = pc[8:4];
    r.br_pred_direction     = 1'b1;
    r.br_pred_target_PC     = pc + 32'h20;
    r.local_pred_direction  = 1'b1;
    r.global_pred_direction = 1'b0;
    return r;
  endfunction

  function automatic RS_BRANCH_PACKET woke(input RS_BRANCH_PACKET q, input logic [31:0] v);
    RS_BRANCH_PACKET r;
    r = q;
    r.opa_ready = 1'b1;
    r.opa_value = v;
    return r;
  endfunction

  task automatic dispatch(input RS_BRANCH_PACKET q);
    dispatch_valid  = 1'b1;
    dispatch_packet = q;
    tick();
    dispatch_valid  = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] v);
    cdb_valid    = 1'b1;
    cdb_preg_idx = tag;
    cdb_value    = v;
    tick();
    cdb_valid    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; squash = 1'b0; dispatch_valid = 1'b0; dispatch_packet = '0;
    cdb_valid = 1'b0; cdb_preg_idx = '0; cdb_value = '0; fu_busy = 1'b0;
    #12;
    check("rst_en",   256'(branch_enable), 256'(0));
    check("rst_full", 256'(rs_branch_full), 256'(0));
    check("rst_pkt",  256'(rs_branch_packet), 256'(0));
    reset = 1'b1;

    // Both operands ready: issue two edges after dispatch.
    p = mk(32'h100, 6'd1, 1'b1, 32'd7, 32'd7);
    dispatch(p);
    check("basic_lat1", 256'(branch_enable), 256'(0));
    tick();
    check("basic_en",   256'(branch_enable), 256'(1));
    check("basic_pkt",  256'(rs_branch_packet), 256'(p));
    check("basic_full", 256'(rs_branch_full), 256'(0));
    tick();
    check("basic_drop", 256'(branch_enable), 256'(0));
    check("basic_hold", 256'(rs_branch_packet), 256'(p));

    // CDB wakeup two cycles after dispatch; a non-matching tag first.
    p = mk(32'h200, 6'd5, 1'b0, 32'd0, 32'd3);
    dispatch(p);
    cdb(6'd6, 32'h55);
    check("wake_none", 256'(branch_enable), 256'(0));
    cdb(6'd5, 32'h10);
    check("wake_lat",  256'(branch_enable), 256'(0));
    tick();
    check("wake_en",   256'(branch_enable), 256'(1));
    check("wake_pkt",  256'(rs_branch_packet), 256'(woke(p, 32'h10)));

    // Same-cycle CDB bypass at dispatch.
    p = mk(32'h240, 6'd9, 1'b0, 32'd0, 32'd4);
    cdb_valid = 1'b1; cdb_preg_idx = 6'd9; cdb_value = 32'h77;
    dispatch(p);
    cdb_valid = 1'b0;
    check("byp_lat", 256'(branch_enable), 256'(0));
    tick();
    check("byp_en",  256'(branch_enable), 256'(1));
    check("byp_pkt", 256'(rs_branch_packet), 256'(woke(p, 32'h77)));

    // Fill, ignore fifth, wake entry 2, refill the freed slot.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) check("fill3_full", 256'(rs_branch_full), 256'(0));
      dispatch(mk(32'h400 + 32'(k) * 32'h10, 6'(10 + k), 1'b0, 32'd0, 32'd1));
    end
    check("full_set", 256'(rs_branch_full), 256'(1));
    dispatch(mk(32'h4f0, 6'd1, 1'b1, 32'd1, 32'd1));
    check("full_5th", 256'(rs_branch_full), 256'(1));
    tick();
    check("full_5th_noiss", 256'(branch_enable), 256'(0));
    cdb(6'd12, 32'h12);
    check("full_wake_en",   256'(branch_enable), 256'(0));
    check("full_wake_full", 256'(rs_branch_full), 256'(1));
    tick();
    check("full_iss_en",  256'(branch_enable), 256'(1));
    check("full_iss_pkt", 256'(rs_branch_packet),
          256'(woke(mk(32'h420, 6'd12, 1'b0, 32'd0, 32'd1), 32'h12)));
    check("full_drop",    256'(rs_branch_full), 256'(0));
    dispatch(mk(32'h4a0, 6'd20, 1'b0, 32'd0, 32'd0));
    check("full_refill",  256'(rs_branch_full), 256'(1));
    squash = 1'b1; tick(); squash = 1'b0;
    check("sq1_full", 256'(rs_branch_full), 256'(0));

    // Age beats index: A lands in entry 1, younger B in entry 0.
    p = mk(32'h300, 6'd1, 1'b1, 32'd1, 32'd1);
    dispatch(p);
    pa = mk(32'h310, 6'd30, 1'b0, 32'd0, 32'd2);
    dispatch(pa);
    check("age_x_en",  256'(branch_enable), 256'(1));
    check("age_x_pkt", 256'(rs_branch_packet), 256'(p));
    pb = mk(32'h320, 6'd30, 1'b0, 32'd0, 32'd3);
    dispatch(pb);
    check("age_b_idle", 256'(branch_enable), 256'(0));
    cdb(6'd30, 32'h30);
    check("age_wake", 256'(branch_enable), 256'(0));
    tick();
    check("age_a_pkt", 256'(rs_branch_packet), 256'(woke(pa, 32'h30)));
    check("age_a_en",  256'(branch_enable), 256'(1));
    tick();
    check("age_b_pkt", 256'(rs_branch_packet), 256'(woke(pb, 32'h30)));
    check("age_b_en",  256'(branch_enable), 256'(1));
    tick();
    check("age_done", 256'(branch_enable), 256'(0));

    // fu_busy held three cycles blocks issue; order preserved afterwards.
    pa = mk(32'h500, 6'd31, 1'b0, 32'd0, 32'd5);
    pb = mk(32'h510, 6'd31, 1'b0, 32'd0, 32'd6);
    dispatch(pa);
    dispatch(pb);
    fu_busy = 1'b1;
    cdb(6'd31, 32'h31);
    for (int k = 0; k < 2; k++) begin
      check("busy_hold", 256'(branch_enable), 256'(0));
      tick();
    end
    check("busy_hold3", 256'(branch_enable), 256'(0));
    fu_busy = 1'b0;
    tick();
    check("busy_a", 256'(rs_branch_packet), 256'(woke(pa, 32'h31)));
    tick();
    check("busy_b", 256'(rs_branch_packet), 256'(woke(pb, 32'h31)));
    check("busy_b_en", 256'(branch_enable), 256'(1));
    tick();

    // Squash with a ready entry, two pending entries and a concurrent dispatch.
    fu_busy = 1'b1;
    dispatch(mk(32'h600, 6'd1, 1'b1, 32'd1, 32'd1));
    dispatch(mk(32'h610, 6'd40, 1'b0, 32'd0, 32'd1));
    dispatch(mk(32'h620, 6'd41, 1'b0, 32'd0, 32'd1));
    fu_busy = 1'b0;
    squash = 1'b1;
    dispatch(mk(32'h640, 6'd1, 1'b1, 32'd1, 32'd1));
    squash = 1'b0;
    check("sq_en",   256'(branch_enable), 256'(0));
    check("sq_full", 256'(rs_branch_full), 256'(0));
    cdb(6'd40, 32'h40);
    for (int k = 0; k < 3; k++) begin
      check("sq_noiss", 256'(branch_enable), 256'(0));
      tick();
    end
    p = mk(32'h680, 6'd1, 1'b1, 32'd8, 32'd9);
    dispatch(p);
    tick();
    check("sq_after_en",  256'(branch_enable), 256'(1));
    check("sq_after_pkt", 256'(rs_branch_packet), 256'(p));
    tick();

    // Asynchronous reset mid-run with three entries still held.
    for (int k = 0; k < 3; k++) dispatch(mk(32'h700 + 32'(k) * 32'h10, 6'(50 + k), 1'b0, 32'd0, 32'd0));
    p = mk(32'h7a0, 6'd1, 1'b1, 32'd2, 32'd2);
    dispatch(p);
    check("rr_full", 256'(rs_branch_full), 256'(1));
    tick();
    check("rr_en_pre", 256'(branch_enable), 256'(1));
    #2 reset = 1'b0;
    #1;
    check("rr_en",   256'(branch_enable), 256'(0));
    check("rr_full0", 256'(rs_branch_full), 256'(0));
    check("rr_pkt",  256'(rs_branch_packet), 256'(0));
    #2 reset = 1'b1;
    tick();
    cdb(6'd50, 32'h50);
    tick();
    check("rr_noiss", 256'(branch_enable), 256'(0));
    p = mk(32'h7c0, 6'd1, 1'b1, 32'd3, 32'd4);
    dispatch(p);
    check("rr_lat", 256'(branch_enable), 256'(0));
    tick();
    check("rr_iss_en",  256'(branch_enable), 256'(1));
    check("rr_iss_pkt", 256'(rs_branch_packet), 256'(p));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
